pll_phase_step_ctrl: RTL and testbench

Fabric-side controller that drives the dynamic phase-adjust inputs of a CCC/PLL wrapper: output select, direction, rotate and load-phase. It accepts step requests over a valid/ready handshake, issues a timed PHASE_ROTATE pulse train, then strobes LOAD_PHASE_N. It tracks the phase position of OUT0, OUT2 and OUT3 and aborts if PLL lock is lost. It sits between the DDR training/calibration logic and the PLL wrapper.

---
 rtl/pll_phase_step_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_pll_phase_step_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_phase_step_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pll_phase_step_ctrl
// Description : Drives the dynamic phase-adjust pins of a CCC/PLL wrapper.
//               Accepts step requests over valid/ready, issues a timed
//               PHASE_ROTATE pulse train, strobes LOAD_PHASE_N, tracks the
//               phase position of OUT0/OUT2/OUT3 and aborts on lock loss.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_phase_step_ctrl #(
    parameter int STEP_W       = 8,
    parameter int PHASE_RES    = 8,
    parameter int SETUP_CYC    = 2,
    parameter int ROT_HIGH_CYC = 2,
    parameter int ROT_GAP_CYC  = 4,
    parameter int LOAD_LOW_CYC = 2,
    localparam int PW          = $clog2(PHASE_RES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_out_sel,
    input  logic              req_direction,
    input  logic [STEP_W-1:0] req_steps,
    input  logic              pll_lock,
    output logic              phase_out0_sel,
    output logic              phase_out2_sel,
    output logic              phase_out3_sel,
    output logic              phase_direction,
    output logic              phase_rotate,
    output logic              load_phase_n,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [STEP_W-1:0] rsp_steps_done,
    output logic [PW-1:0]     pos0,
    output logic [PW-1:0]     pos2,
    output logic [PW-1:0]     pos3,
    output logic              busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_ROT_HI  = 3'd2;
    localparam logic [2:0] S_ROT_GAP = 3'd3;
    localparam logic [2:0] S_LOAD    = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    // Counter reload values: each timed state runs until the counter hits 0.
    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] HIGH_LD  = 4'(ROT_HIGH_CYC - 1);
    localparam logic [3:0] GAP_LD   = 4'(ROT_GAP_CYC - 1);
    localparam logic [3:0] LOAD_LD  = 4'(LOAD_LOW_CYC - 1);

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nx;
    logic              err_flag;
    logic              err_nx;
    logic [1:0]        cap_sel;
    logic              cap_dir;
    logic [STEP_W-1:0] cap_steps;
    logic [STEP_W-1:0] steps_done;
    logic              accept;
    logic              enter_rot;
    logic              pins_active;
    logic [PW-1:0]     pos_delta;

    assign accept      = (state == S_IDLE) && req_valid;
    assign enter_rot   = (state_nx == S_ROT_HI) && (state != S_ROT_HI);
    assign pins_active = (state == S_SETUP) || (state == S_ROT_HI) ||
                         (state == S_ROT_GAP) || (state == S_LOAD);
    // Advance adds one position, retard adds all-ones (i.e. subtracts one).
    assign pos_delta   = cap_dir ? PW'(1) : {PW{1'b1}};

    // Next-state, duration counter and error-flag selection; lock loss wins
    // over every timed transition.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        err_nx   = err_flag;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if ((req_out_sel == 2'd3) || !pll_lock) begin
                        state_nx = S_RESP;
                        err_nx   = 1'b1;
                    end else if (req_steps == '0) begin
                        state_nx = S_RESP;
                        err_nx   = 1'b0;
                    end else begin
                        state_nx = S_SETUP;
                        cnt_nx   = SETUP_LD;
                        err_nx   = 1'b0;
                    end
                end
            end
            S_SETUP, S_ROT_HI, S_ROT_GAP, S_LOAD: begin
                if (!pll_lock) begin
                    state_nx = S_RESP;
                    err_nx   = 1'b1;
                end else if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    case (state)
                        S_SETUP: begin
                            state_nx = S_ROT_HI;
                            cnt_nx   = HIGH_LD;
                        end
                        S_ROT_HI: begin
                            state_nx = S_ROT_GAP;
                            cnt_nx   = GAP_LD;
                        end
                        S_ROT_GAP: begin
                            if (steps_done < cap_steps) begin
                                state_nx = S_ROT_HI;
                                cnt_nx   = HIGH_LD;
                            end else begin
                                state_nx = S_LOAD;
                                cnt_nx   = LOAD_LD;
                            end
                        end
                        default: state_nx = S_RESP;
                    endcase
                end
            end
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // FSM state, captured request fields and step/position tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            err_flag   <= 1'b0;
            cap_sel    <= 2'd0;
            cap_dir    <= 1'b0;
            cap_steps  <= '0;
            steps_done <= '0;
            pos0       <= '0;
            pos2       <= '0;
            pos3       <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            err_flag <= err_nx;
            if (accept) begin
                cap_sel    <= req_out_sel;
                cap_dir    <= req_direction;
                cap_steps  <= req_steps;
                steps_done <= '0;
            end
            if (enter_rot) begin
                steps_done <= steps_done + 1'b1;
                case (cap_sel)
                    2'd0:    pos0 <= pos0 + pos_delta;
                    2'd1:    pos2 <= pos2 + pos_delta;
                    2'd2:    pos3 <= pos3 + pos_delta;
                    default: ;
                endcase
            end
        end
    end

    // Registered pin and response outputs, decoded from the current state.
    // Ready/busy follow the next state so a request is never offered a
    // ready that the FSM will not honour.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready       <= 1'b1;
            busy            <= 1'b0;
            phase_out0_sel  <= 1'b0;
            phase_out2_sel  <= 1'b0;
            phase_out3_sel  <= 1'b0;
            phase_direction <= 1'b0;
            phase_rotate    <= 1'b0;
            load_phase_n    <= 1'b1;
            rsp_valid       <= 1'b0;
            rsp_err         <= 1'b0;
            rsp_steps_done  <= '0;
        end else begin
            req_ready       <= (state_nx == S_IDLE);
            busy            <= (state_nx != S_IDLE);
            phase_out0_sel  <= pins_active && (cap_sel == 2'd0);
            phase_out2_sel  <= pins_active && (cap_sel == 2'd1);
            phase_out3_sel  <= pins_active && (cap_sel == 2'd2);
            phase_direction <= pins_active && cap_dir;
            phase_rotate    <= (state == S_ROT_HI);
            load_phase_n    <= (state != S_LOAD);
            rsp_valid       <= (state == S_RESP);
            if (state == S_RESP) begin
                rsp_err        <= err_flag;
                rsp_steps_done <= steps_done;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pll_phase_step_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pll_phase_step_ctrl
// Description : Scoreboard bench for pll_phase_step_ctrl with a queue-based
//               reference model and randomized requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_phase_step_ctrl;

    localparam int STEP_W = 8;
    localparam int PRES   = 8;
    localparam int PW     = 3;
    localparam int S      = 2;
    localparam int H      = 2;
    localparam int G      = 4;
    localparam int L      = 2;
    localparam int P      = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_out_sel;
    logic              req_direction;
    logic [STEP_W-1:0] req_steps;
    logic              pll_lock;
    logic              phase_out0_sel, phase_out2_sel, phase_out3_sel;
    logic              phase_direction, phase_rotate, load_phase_n;
    logic              rsp_valid, rsp_err;
    logic [STEP_W-1:0] rsp_steps_done;
    logic [PW-1:0]     pos0, pos2, pos3;
    logic              busy;

    always #(P/2) clk = ~clk;

    pll_phase_step_ctrl #(
        .STEP_W(STEP_W), .PHASE_RES(PRES), .SETUP_CYC(S),
        .ROT_HIGH_CYC(H), .ROT_GAP_CYC(G), .LOAD_LOW_CYC(L)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_out_sel(req_out_sel), .req_direction(req_direction),
        .req_steps(req_steps), .pll_lock(pll_lock),
        .phase_out0_sel(phase_out0_sel), .phase_out2_sel(phase_out2_sel),
        .phase_out3_sel(phase_out3_sel), .phase_direction(phase_direction),
        .phase_rotate(phase_rotate), .load_phase_n(load_phase_n),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_steps_done(rsp_steps_done), .pos0(pos0), .pos2(pos2),
        .pos3(pos3), .busy(busy)
    );

    typedef struct {
        bit  err;
        int  steps;
        int  p0, p2, p3;
        int  sel;       // 3 = no pins may move
        bit  dir;
        bit  chk_lat;
        int  lat;
        int  pulses;
        int  rot_cyc;
        int  load_cyc;
        time t_acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   mpos[3];          // model positions for OUT0, OUT2, OUT3

    int   pulses_seen, rot_seen, load_seen, sel_bad, proto_bad;
    bit   prev_rot;

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [2:0] onehot(input int sel);
        case (sel)
            0:       return 3'b001;
            1:       return 3'b010;
            2:       return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic clear_mon();
        pulses_seen = 0; rot_seen = 0; load_seen = 0;
        sel_bad = 0; proto_bad = 0; prev_rot = 0;
    endtask

    // Monitor: accumulates pin activity and checks every response against
    // the oldest expectation in the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            clear_mon();
        end else begin
            if (busy === req_ready) proto_bad++;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_err", rsp_err, e.err);
                    check("rsp_steps_done", rsp_steps_done, e.steps);
                    check("pos0", pos0, e.p0);
                    check("pos2", pos2, e.p2);
                    check("pos3", pos3, e.p3);
                    if (e.chk_lat)
                        check("latency", (int'($time - e.t_acc) - P/2) / P, e.lat);
                    check("rotate_pulses", pulses_seen, e.pulses);
                    check("rotate_high_cycles", rot_seen, e.rot_cyc);
                    check("load_low_cycles", load_seen, e.load_cyc);
                    check("pin_select_errors", sel_bad, 0);
                    check("ready_busy_errors", proto_bad, 0);
                    check("rsp_pins_idle",
                          {phase_rotate, !load_phase_n, phase_out0_sel,
                           phase_out2_sel, phase_out3_sel, phase_direction}, 0);
                end
                clear_mon();
            end else begin
                if (phase_rotate) begin
                    rot_seen++;
                    if (!prev_rot) pulses_seen++;
                end
                if (!load_phase_n) load_seen++;
                if (phase_rotate || !load_phase_n || phase_out0_sel ||
                    phase_out2_sel || phase_out3_sel || phase_direction) begin
                    if (exp_q.size() == 0)
                        sel_bad++;
                    else if ({phase_out3_sel, phase_out2_sel, phase_out0_sel} != onehot(exp_q[0].sel) ||
                             phase_direction != exp_q[0].dir)
                        sel_bad++;
                end
            end
            prev_rot = phase_rotate;
        end
    end

    // Reference model: outcome of one request from the behavioural rules.
    task automatic build_exp(input int sel, input bit dir, input int steps,
                             input int abort_k, input bit lock_ok, output exp_t e);
        int n;
        e = '{default: 0};
        e.t_acc = $time;
        e.sel   = 3;
        if (sel == 3 || !lock_ok) begin
            e.err = 1; e.chk_lat = 1; e.lat = 1;
        end else if (steps == 0) begin
            e.chk_lat = 1; e.lat = 1;
        end else begin
            n = (abort_k > 0) ? abort_k : steps;
            mpos[sel] = dir ? (mpos[sel] + n) % PRES
                            : (((mpos[sel] - n) % PRES) + PRES) % PRES;
            e.sel      = sel;
            e.dir      = dir;
            e.err      = (abort_k > 0);
            e.steps    = n;
            e.pulses   = n;
            e.rot_cyc  = n * H;
            e.load_cyc = (abort_k > 0) ? 0 : L;
            e.chk_lat  = (abort_k == 0);
            e.lat      = S + steps * (H + G) + L + 1;
        end
        e.p0 = mpos[0]; e.p2 = mpos[1]; e.p3 = mpos[2];
    endtask

    task automatic wait_empty();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            check("rsp_timeout", 0, 1);
            exp_q.delete();
        end
        #1;
    endtask

    // Issues one request, optionally dropping lock inside the abort_k-th gap.
    task automatic do_req(input int sel, input bit dir, input int steps,
                          input int abort_k, input bit lock_ok);
        exp_t e;
        bit   rdy = 0;
        int   guard = 0;
        pll_lock      = lock_ok;
        req_out_sel   = 2'(sel);
        req_direction = dir;
        req_steps     = STEP_W'(steps);
        req_valid     = 1'b1;
        while (!rdy && guard < 200) begin
            rdy = req_ready;
            @(posedge clk);
            guard++;
        end
        if (!rdy) begin
            check("accept_timeout", 0, 1);
            #1 req_valid = 1'b0;
            pll_lock = 1'b1;
            return;
        end
        build_exp(sel, dir, steps, abort_k, lock_ok, e);
        exp_q.push_back(e);
        #1 req_valid = 1'b0;
        if (abort_k > 0) begin
            repeat (S + (abort_k - 1) * (H + G) + H - 1) @(posedge clk);
            @(posedge clk);
            #1 pll_lock = 1'b0;
        end
        wait_empty();
        pll_lock = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        bit   rdy, prv;
        int   cnt, guard, acc;
        int   sel, steps, ab;
        bit   dir, lk;

        mpos = '{0, 0, 0};
        clear_mon();
        reset = 1'b1; req_valid = 1'b0; req_out_sel = 2'd0;
        req_direction = 1'b0; req_steps = '0; pll_lock = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", req_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_pins", {phase_out0_sel, phase_out2_sel, phase_out3_sel,
                             phase_direction, phase_rotate, load_phase_n}, 6'b000001);
        check("reset_rsp", {rsp_valid, rsp_err, rsp_steps_done}, 0);
        check("reset_pos", {pos0, pos2, pos3}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        do_req(1, 1, 3, 0, 1);      // OUT2 advance 3
        do_req(0, 0, 1, 0, 1);      // OUT0 retard wraps to 7
        do_req(0, 1, 9, 0, 1);      // OUT0 advance 9 wraps back to 0
        do_req(2, 1, 0, 0, 1);      // zero steps
        do_req(3, 1, 4, 0, 1);      // invalid select
        do_req(2, 1, 5, 3, 1);      // OUT3, lock lost in 3rd gap
        do_req(0, 1, 2, 0, 0);      // lock already low at accept

        // Reset during the 2nd rotate pulse.
        req_out_sel = 2'd1; req_direction = 1'b1; req_steps = 8'd4;
        req_valid = 1'b1;
        rdy = 0; guard = 0;
        while (!rdy && guard < 200) begin
            rdy = req_ready;
            @(posedge clk);
            guard++;
        end
        build_exp(1, 1, 4, 0, 1, e);
        exp_q.push_back(e);
        #1 req_valid = 1'b0;
        cnt = 0; guard = 0; prv = 0;
        while (cnt < 2 && guard < 100) begin
            @(negedge clk);
            if (phase_rotate && !prv) cnt++;
            prv = phase_rotate;
            guard++;
        end
        check("reset_test_second_pulse_seen", cnt, 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midop_reset_pins", {phase_out0_sel, phase_out2_sel, phase_out3_sel,
                                   phase_direction, phase_rotate, load_phase_n}, 6'b000001);
        check("midop_reset_pos", {pos0, pos2, pos3}, 0);
        check("midop_reset_ready", {req_ready, busy, rsp_valid}, 3'b100);
        reset = 1'b0;
        exp_q.delete();
        mpos = '{0, 0, 0};
        clear_mon();
        repeat (40) @(posedge clk);
        #1;

        // Valid held high across busy periods: one accept per idle visit.
        req_out_sel = 2'd2; req_direction = 1'b0; req_steps = 8'd2;
        req_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 60; i++) begin
            rdy = req_ready;
            @(posedge clk);
            if (rdy) begin
                build_exp(2, 0, 2, 0, 1, e);
                exp_q.push_back(e);
                acc++;
            end
            #1;
        end
        req_valid = 1'b0;
        wait_empty();
        check("b2b_multiple_accepts", (acc >= 3), 1);

        // Randomized requests against the model.
        for (int i = 0; i < 25; i++) begin
            sel   = $urandom_range(0, 3);
            dir   = 1'($urandom_range(0, 1));
            steps = $urandom_range(0, 5);
            ab    = (steps > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, steps) : 0;
            lk    = ($urandom_range(0, 7) != 0);
            do_req(sel, dir, steps, ab, lk);
        end

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
